// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative I-cache, one word per line, age-based victim choice; fence_i only with ICACHE_FENCEI_EN
module icache_nway #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int ADDR_W = 64,
  parameter int AGE_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
`ifdef ICACHE_FENCEI_EN
  ,
  input  logic              fence_i
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP} state_t;

  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0] r_data;
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] r_age;
  logic [TAG_W-1:0] r_tag [SETS][WAYS];
  logic [31:0] r_mem [SETS][WAYS];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic w_hit, w_fill, w_touch, w_fence_now;
  logic [WAY_W-1:0] w_hit_way, w_vic, w_acc_way;
  logic [31:0] w_hit_data;
  logic [AGE_W-1:0] w_max_age;
  logic [WAYS-1:0][AGE_W-1:0] w_age_nxt;

  assign w_idx = r_addr[IDX_W+1:2];
  assign w_tag = r_addr[ADDR_W-1:IDX_W+2];
  assign w_fill = r_state == MISS_WAIT && mem_resp_valid;
  assign w_touch = (r_state == LOOKUP && w_hit) || w_fill;
  assign w_acc_way = (r_state == LOOKUP) ? w_hit_way : w_vic;

`ifdef ICACHE_FENCEI_EN
  logic r_fence_pend;
  assign w_fence_now = r_state == IDLE && (fence_i || r_fence_pend);
  // remember a fence seen while busy so it lands on the next idle cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_fence_pend <= 1'b0;
    else r_fence_pend <= (r_state == IDLE) ? 1'b0 : (r_fence_pend || fence_i);
`else
  assign w_fence_now = 1'b0;
`endif

  assign req_ready = rst && r_state == IDLE && !w_fence_now;
  assign resp_valid = r_state == RESP;
  assign resp_data = (r_state == RESP) ? r_data : 32'd0;
  assign mem_req_valid = r_state == MISS_REQ;
  assign mem_addr = (r_state == MISS_REQ) ? (r_addr & ~ADDR_W'(3)) : '0;

  // tag compare across the set; lowest matching way wins
  always_comb begin
    w_hit = 1'b0;
    w_hit_way = '0;
    w_hit_data = '0;
    for (int i = 0; i < WAYS; i++)
      if (!w_hit && r_valid[w_idx][i] && r_tag[w_idx][i] == w_tag) begin
        w_hit = 1'b1;
        w_hit_way = WAY_W'(i);
        w_hit_data = r_mem[w_idx][i];
      end
  end

  // victim: lowest invalid way, otherwise oldest way with ties to the lowest index
  always_comb begin
    w_vic = '0;
    w_max_age = r_age[w_idx][0];
    for (int i = 1; i < WAYS; i++)
      if (r_age[w_idx][i] > w_max_age) begin
        w_max_age = r_age[w_idx][i];
        w_vic = WAY_W'(i);
      end
    for (int i = WAYS - 1; i >= 0; i--)
      if (!r_valid[w_idx][i]) w_vic = WAY_W'(i);
  end

  // accessed way becomes youngest, the rest age with saturation
  always_comb begin
    for (int i = 0; i < WAYS; i++)
      w_age_nxt[i] = (WAY_W'(i) == w_acc_way) ? '0 :
                     (r_age[w_idx][i] == AGE_MAX) ? AGE_MAX : r_age[w_idx][i] + 1'b1;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = (req_valid && req_ready) ? LOOKUP : IDLE;
      LOOKUP:    w_next = w_hit ? RESP : MISS_REQ;
      MISS_REQ:  w_next = mem_req_ready ? MISS_WAIT : MISS_REQ;
      MISS_WAIT: w_next = mem_resp_valid ? RESP : MISS_WAIT;
      RESP:      w_next = resp_ready ? IDLE : RESP;
      default:   w_next = IDLE;
    endcase
  end

  // state, captured address and response word
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      if (req_valid && req_ready) r_addr <= req_addr;
      if (r_state == LOOKUP && w_hit) r_data <= w_hit_data;
      if (w_fill) r_data <= mem_resp_data;
    end

  // valid bits and ages; cleared by reset and fence
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_valid <= '0;
      r_age <= '0;
    end else if (w_fence_now) begin
      r_valid <= '0;
      r_age <= '0;
    end else if (w_touch) begin
      if (w_fill) r_valid[w_idx][w_vic] <= 1'b1;
      r_age[w_idx] <= w_age_nxt;
    end

  // data and tag storage is not reset; validity guards it
  always_ff @(posedge clk)
    if (w_fill) begin
      r_mem[w_idx][w_vic] <= mem_resp_data;
      r_tag[w_idx][w_vic] <= w_tag;
    end
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: randomized and directed checks of icache_nway against an LRU-list reference model
module tb_icache_nway;
  localparam int WAYS = 2;
  localparam int SETS = 64;

  logic        clk = 0;
  logic        rst = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 0;
  logic [31:0] resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 0;
  logic [63:0] mem_addr;
  logic        mem_resp_valid = 0;
  logic [31:0] mem_resp_data = '0;
`ifdef ICACHE_FENCEI_EN
  logic        fence_i = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [61:0] q_set [SETS][$];

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(64), .AGE_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef ICACHE_FENCEI_EN
    , .fence_i(fence_i)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] l;
    l = a >> 2;
    if (l == 64'h2000_0000) return 32'h0000_0013;
    return l[31:0] * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) q_set[s].delete();
  endtask

  task automatic do_fetch(input logic [63:0] a, input int mstall, input int rstall,
                          input bit abort, input bit fence_mid, output bit hit);
    int idx, found, n;
    logic [61:0] line;
    logic [31:0] exp_d;
    bit exp_hit;
    idx = int'(a[7:2]);
    line = a[63:2];
    found = -1;
    for (int k = 0; k < q_set[idx].size(); k++) if (q_set[idx][k] == line) found = k;
    exp_hit = found >= 0;
    exp_d = mem_word(a);
    hit = 0;
    req_valid = 1;
    req_addr = a;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", a, req_ready);
      req_valid = 0;
      return;
    end
    @(negedge clk);
    req_valid = 0;
    req_addr = {$urandom, $urandom};
    mem_resp_valid = 1'($urandom);
    mem_resp_data = $urandom;
    checks++;
    if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL lookup_quiet addr=%h resp_valid=%b mem_req_valid=%b required 0 0", a, resp_valid, mem_req_valid);
    end
    @(negedge clk);
    mem_resp_valid = 0;
    hit = resp_valid;
    checks++;
    if (resp_valid !== exp_hit) begin
      errors++;
      $display("FAIL hit_decision addr=%h got %b required %b", a, resp_valid, exp_hit);
    end
    if (resp_valid) begin
      checks++;
      if (mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hit_no_refill addr=%h mem_req_valid=%b required 0", a, mem_req_valid);
      end
    end else begin
      checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== (a & ~64'h3)) begin
        errors++;
        $display("FAIL mem_req addr=%h valid=%b mem_addr=%h required 1 %h", a, mem_req_valid, mem_addr, a & ~64'h3);
      end
      for (int k = 0; k < mstall; k++) begin
        mem_req_ready = 0;
        mem_resp_valid = 1'($urandom);
        mem_resp_data = $urandom;
`ifdef ICACHE_FENCEI_EN
        if (fence_mid && k == 0) fence_i = 1;
`endif
        @(negedge clk);
`ifdef ICACHE_FENCEI_EN
        fence_i = 0;
`endif
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== (a & ~64'h3) || resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL mem_hold addr=%h valid=%b mem_addr=%h resp_valid=%b required 1 %h 0", a, mem_req_valid, mem_addr, resp_valid, a & ~64'h3);
        end
      end
      mem_resp_valid = 0;
      mem_req_ready = 1;
`ifdef ICACHE_FENCEI_EN
      if (fence_mid && mstall == 0) fence_i = 1;
`endif
      @(negedge clk);
      mem_req_ready = 0;
`ifdef ICACHE_FENCEI_EN
      fence_i = 0;
`endif
      checks++;
      if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mem_wait addr=%h mem_req_valid=%b resp_valid=%b required 0 0", a, mem_req_valid, resp_valid);
      end
      if (abort) return;
      n = $urandom_range(0, 2);
      repeat (n) @(negedge clk);
      mem_resp_valid = 1;
      mem_resp_data = exp_d;
      @(negedge clk);
      mem_resp_valid = 0;
      mem_resp_data = $urandom;
    end
    for (int k = 0; k < rstall; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp_d || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold addr=%h valid=%b data=%h req_ready=%b required 1 %h 0", a, resp_valid, resp_data, req_ready, exp_d);
      end
      @(negedge clk);
    end
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== exp_d) begin
      errors++;
      $display("FAIL resp addr=%h valid=%b data=%h required 1 %h", a, resp_valid, resp_data, exp_d);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin
      errors++;
      $display("FAIL resp_done addr=%h valid=%b data=%h required 0 0", a, resp_valid, resp_data);
    end
    if (found >= 0) q_set[idx].delete(found);
    q_set[idx].push_front(line);
    if (q_set[idx].size() > WAYS) void'(q_set[idx].pop_back());
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'd0 ||
        mem_req_valid !== 1'b0 || mem_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs req_ready=%b resp_valid=%b resp_data=%h mem_req_valid=%b mem_addr=%h required all 0",
               req_ready, resp_valid, resp_data, mem_req_valid, mem_addr);
    end
    rst = 1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release req_ready=%b required 1", req_ready);
    end
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    bit h;
    do_fetch(64'h8000_0000, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL cold_miss hit=%b required 0", h);
    end
  endtask

  task automatic test_hit_latency();
    bit h;
    do_fetch(64'h8000_0000, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL hit_latency hit=%b required 1", h);
    end
  endtask

  task automatic test_eviction();
    bit h;
    do_fetch(64'h8000_0100, 1, 0, 0, 0, h);
    do_fetch(64'h8000_0200, 0, 1, 0, 0, h);
    do_fetch(64'h8000_0100, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL evict_keep 0x80000100 hit=%b required 1", h);
    end
    do_fetch(64'h8000_0000, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL evict_oldest 0x80000000 hit=%b required 0", h);
    end
  endtask

  task automatic test_backpressure();
    bit h;
    do_fetch(64'h8000_0304, 4, 5, 0, 0, h);
    do_fetch(64'h8000_0304, 0, 5, 0, 0, h);
  endtask

  task automatic test_reset_mid_miss();
    bit h;
    do_fetch(64'h8000_0800, 0, 0, 1, 0, h);
    #2 rst = 0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid resp_valid=%b req_ready=%b mem_req_valid=%b mem_addr=%h required 0 0 0 0",
               resp_valid, req_ready, mem_req_valid, mem_addr);
    end
    @(posedge clk);
    #2 rst = 1;
    model_clear();
    @(negedge clk);
    mem_resp_valid = 1;
    mem_resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_resp_valid = 0;
    repeat (2) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL stale_mem_resp resp_valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
      end
      @(negedge clk);
    end
    do_fetch(64'h8000_0800, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL reset_refetch hit=%b required 0", h);
    end
    do_fetch(64'h8000_0100, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL reset_cleared hit=%b required 0", h);
    end
  endtask

`ifdef ICACHE_FENCEI_EN
  task automatic test_fence();
    bit h;
    do_fetch(64'h8000_0100, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL fence_pre hit=%b required 1", h);
    end
    do_fetch(64'h8000_1004, 2, 1, 0, 1, h);
    model_clear();
    do_fetch(64'h8000_0100, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL fence_pending hit=%b required 0", h);
    end
    fence_i = 1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fence_idle_ready req_ready=%b required 0", req_ready);
    end
    @(negedge clk);
    fence_i = 0;
    model_clear();
    do_fetch(64'h8000_0100, 0, 0, 0, 0, h);
    checks++;
    if (h !== 1'b0) begin
      errors++;
      $display("FAIL fence_idle hit=%b required 0", h);
    end
  endtask
`endif

  task automatic test_random();
    bit h;
    logic [63:0] a;
    for (int i = 0; i < 300; i++) begin
      a = 64'h8000_0000 + 64'($urandom_range(0, 4)) * 256 + 64'($urandom_range(0, 2)) * 4 + 64'($urandom_range(0, 3));
      do_fetch(a, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, h);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_latency();
    test_eviction();
    test_backpressure();
    test_reset_mid_miss();
`ifdef ICACHE_FENCEI_EN
    test_fence();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
